// File: rtl/tt_lut.sv
// tt_lut: registered single-output truth-table lookup with a double-buffered serial reload.
// Optional macro TT_LUT_SWEEP_EN adds sweep_start/out_last and a SWEEP state that streams the table.
module tt_lut #(
    parameter int                      N_IN       = 3,
    parameter logic [(1 << N_IN)-1:0]  DEFAULT_TT = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_start,
    input  logic            load_valid,
    input  logic            load_bit,
    output logic            load_done,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic            out_data,
    input  logic            out_ready,
`ifdef TT_LUT_SWEEP_EN
    input  logic            sweep_start,
    output logic            out_last,
`endif
    output logic            busy
);

    localparam int              ROWS     = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_ROW = '1;

    typedef enum logic [1:0] {
        ST_READY,
        ST_LOAD
`ifdef TT_LUT_SWEEP_EN
        , ST_SWEEP
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ROWS-1:0]   r_tt;
    logic [ROWS-1:0]   r_shadow;
    logic [ROWS-1:0]   w_shadow_next;
    logic [N_IN-1:0]   r_cnt;
    logic              r_out_valid;
    logic              r_out_data;
    logic              r_load_done;
    logic              w_xfer;
    logic              w_wr_en;
    logic [N_IN-1:0]   w_wr_idx;
    logic              w_last_wr;
`ifdef TT_LUT_SWEEP_EN
    logic              r_out_last;
    logic              w_sweep_emit;
`endif

    assign busy      = (r_state != ST_READY);
    assign in_ready  = (r_state == ST_READY) && (!r_out_valid || out_ready);
    assign w_xfer    = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign load_done = r_load_done;

    // A restart coincident with a valid bit makes that bit row 0.
    assign w_wr_en   = (r_state == ST_LOAD) && load_valid;
    assign w_wr_idx  = load_start ? '0 : r_cnt;
    assign w_last_wr = w_wr_en && (w_wr_idx == LAST_ROW);

`ifdef TT_LUT_SWEEP_EN
    assign out_last     = r_out_last;
    assign w_sweep_emit = (r_state == ST_SWEEP) && !(r_out_valid && r_out_last)
                          && (!r_out_valid || out_ready);
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_wr_en) begin
            w_shadow_next[w_wr_idx] = load_bit;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_READY: begin
                if (load_start) begin
                    w_state_next = ST_LOAD;
                end
`ifdef TT_LUT_SWEEP_EN
                else if (sweep_start) begin
                    w_state_next = ST_SWEEP;
                end
`endif
            end
            ST_LOAD: begin
                if (w_last_wr) begin
                    w_state_next = ST_READY;
                end
            end
`ifdef TT_LUT_SWEEP_EN
            ST_SWEEP: begin
                if (r_out_valid && r_out_last && out_ready) begin
                    w_state_next = ST_READY;
                end
            end
`endif
            default: w_state_next = ST_READY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the shadow table has no reset; every row is rewritten before it can reach r_tt.
    always_ff @(posedge clk) begin
        r_shadow <= w_shadow_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tt        <= DEFAULT_TT;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 1'b0;
            r_load_done <= 1'b0;
`ifdef TT_LUT_SWEEP_EN
            r_out_last  <= 1'b0;
`endif
        end else begin
            r_load_done <= w_last_wr;
            if (w_last_wr) begin
                r_tt <= w_shadow_next;
            end

            if (r_state == ST_READY && w_state_next == ST_LOAD) begin
                r_cnt <= '0;
            end else if (w_wr_en) begin
                r_cnt <= w_wr_idx + N_IN'(1);
            end else if (r_state == ST_LOAD && load_start) begin
                r_cnt <= '0;
            end
`ifdef TT_LUT_SWEEP_EN
            else if (r_state == ST_READY && w_state_next == ST_SWEEP) begin
                r_cnt <= '0;
            end else if (w_sweep_emit) begin
                r_cnt <= r_cnt + N_IN'(1);
            end
`endif

            // The output register always holds its value while stalled by out_ready.
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_tt[in_data];
`ifdef TT_LUT_SWEEP_EN
                r_out_last  <= 1'b0;
`endif
            end
`ifdef TT_LUT_SWEEP_EN
            else if (w_sweep_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_tt[r_cnt];
                r_out_last  <= (r_cnt == LAST_ROW);
            end
`endif
            else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
`ifdef TT_LUT_SWEEP_EN
                r_out_last  <= 1'b0;
`endif
            end
        end
    end

endmodule
